round_robin_arbiter_n: RTL and testbench
========================================

// Module: round_robin_arbiter_n
// PURPOSE
//  N-requester round-robin arbiter with registered grant and transfer lock.
//  - Generalises the fixed 4-way arbiter to N requesters.
//  - A granted requester keeps the grant until it drops its request or pulses release.
//  - Fair rotation and back-to-back handover with no idle cycle.
//  - Arbitrates the MAC transmit/receive clients for the shared packet datapath.
// PARAMETERS
//  N          4    number of requesters, 2..32
//  IDX_W      2    width of grant_index, = clog2(N)
//  MAX_HOLD   64   max grant length in cycles, 1..2^16; used only with ARB_MAX_HOLD_EN
// PORTS
//  clock        in   1      single clock; all state updates on its rising edge
//  reset_n      in   1      asynchronous, active-low reset
//  request      in   N      per-requester request level
//  release      in   1      current grantee ends its transfer this cycle
//  grant        out  N      one-hot registered grant, all-zero when idle
//  grant_index  out  IDX_W  binary index of the grantee, valid when grant_valid=1
//  grant_valid  out  1      =|grant
// BEHAVIOUR
//  - Reset (async assert, sync deassert by system): grant=0, grant_index=0,
//    grant_valid=0, pointer=0, state=IDLE, hold counter=0.
//  - pointer: the highest-priority requester index.
//  - Selection: first set bit of request at or above pointer, wrapping mod N.
//  - IDLE: if request!=0 at edge k, the winner's grant is visible after edge k.
//    Latency is 1 cycle. State goes to BUSY. pointer=winner+1 mod N.
//  - BUSY: grant is held while request[grant_index]=1 and release=0.
//  - End of transfer: request[grant_index]=0 or release=1 at edge k.
//    Re-arbitrate at the same edge with the current grantee masked out.
//    If another requester wins, its grant is visible after edge k.
//    There is no bubble, and pointer=new winner+1.
//    If no other requester, grant=0 and state=IDLE. A grantee that is still
//    requesting is re-granted through IDLE on edge k+1.
//  - release while grant_valid=0 is ignored.
//  - request bits change freely; only bits sampled at the arbitration edge count.
//  - A request for a bit other than the grantee during BUSY never changes grant.
//  - Wrap-around: pointer goes N-1 -> 0. Requester N-1 winning sets pointer=0.
//  - grant is always one-hot or zero. grant_index and grant come from the same register update.
//  - Reset mid-transfer: outputs clear immediately and asynchronously. No grant is
//    restored after reset deasserts, and arbitration restarts from pointer=0.
// CONFIGURATION
//  - ARB_MAX_HOLD_EN defined:
//    - A 16-bit hold counter clears on each new grant and counts BUSY cycles.
//    - When the count reaches MAX_HOLD, the arbiter treats that edge as end of
//      transfer (forced re-arbitration, grantee masked).
//    - The preempted requester may regain the grant only once no one else is requesting.
//  - ARB_MAX_HOLD_EN undefined: no counter and no preemption. The grant is
//    unbounded, and MAX_HOLD is unused.
// STRUCTURE
//  - Shared package mac_arb_pkg:
//    - state encoding constants ARB_IDLE=1'b0, ARB_BUSY=1'b1;
//    - clog2 function;
//    - width of the hold counter, ARB_HOLD_W=16.
//  - Sub-module rr_priority_select (combinational, parameter N).
//    - Inputs: req[N], mask[N], pointer[IDX_W].
//    - Outputs: sel_onehot[N], sel_index[IDX_W], sel_valid.
//    - Handles the rotated priority encode with wrap.
//  - The top level holds the state register, pointer, grant registers and the
//    optional hold counter.
// TESTING (N=4)
//  - Reset, then request=4'b0101 and hold.
//    -> grant=0001 at the first edge after reset release, index 0.
//  - Release pulsed with request=0101 held, then request[0] dropped.
//    -> grant=0100 at the release edge, with no zero cycle.
//    -> After that 0100 ends, grant=0001 only if request[0] has re-asserted.
//  - request=1111, release pulsed every cycle.
//    -> grant sequence 0001,0010,0100,1000,0001 (wrap check).
//    -> grant is one-hot each cycle.
//  - Single requester 4'b1000 drops its request for one cycle, then re-raises.
//    -> grant 1000, then 0000, then 1000. grant_valid tracks this.
//  - reset_n pulled low asynchronously mid-BUSY (between edges).
//    -> grant=0 and grant_valid=0 immediately.
//    -> After reset deasserts with request=0010, grant=0010.
//  - With ARB_MAX_HOLD_EN and MAX_HOLD=3: request=0011, no release.
//    -> grant 0001 for 3 cycles, then 0010 for 3 cycles, alternating.
//    -> Without the macro, grant stays 0001 forever.

Source files
------------

// File: rtl/mac_arb_pkg.sv
// Shared definitions for the MAC datapath arbiter: state encoding, hold-counter width, clog2.
package mac_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int unsigned ARB_HOLD_W = 16;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Rotated priority encoder: first unmasked request at or above the pointer, wrapping mod N.
module rr_priority_select
    import mac_arb_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [N-1:0]     i_mask,
    input  logic [IDX_W-1:0] i_pointer,
    output logic [N-1:0]     o_sel_onehot_c,
    output logic [IDX_W-1:0] o_sel_index_c,
    output logic             o_sel_valid_c
);

    logic [N-1:0]     w_cand;
    logic [N-1:0]     w_rot;
    logic [IDX_W-1:0] w_off;
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_idx;
    logic             w_hit;

    assign w_cand = i_req & ~i_mask;
    // Rotate so the pointer position lands at bit 0; the doubled vector provides the wrap.
    assign w_rot  = N'({w_cand, w_cand} >> i_pointer);
    assign w_hit  = |w_rot;

    always_comb begin
        w_off = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_sum = {1'b0, i_pointer} + {1'b0, w_off};
        if (w_sum >= (IDX_W+1)'(N)) begin
            w_idx = IDX_W'(w_sum - (IDX_W+1)'(N));
        end else begin
            w_idx = IDX_W'(w_sum);
        end
    end

    assign o_sel_valid_c  = w_hit;
    assign o_sel_index_c  = w_hit ? w_idx : '0;
    assign o_sel_onehot_c = w_hit ? (N'(1) << w_idx) : '0;

endmodule

// File: rtl/round_robin_arbiter_n.sv
// N-requester round-robin arbiter with registered grant, transfer lock and zero-bubble handover.
// Optional grant-length limit enabled by defining ARB_MAX_HOLD_EN.
module round_robin_arbiter_n
    import mac_arb_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned IDX_W    = clog2(N),
    parameter int unsigned MAX_HOLD = 64
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic [N-1:0]     i_request,
    input  logic             i_release,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_grant_index,
    output logic             o_grant_valid
);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_pointer;
    logic [IDX_W-1:0] w_pointer_nxt;
    logic [N-1:0]     r_grant;
    logic [N-1:0]     w_grant_nxt;
    logic [IDX_W-1:0] r_grant_index;
    logic [IDX_W-1:0] w_index_nxt;
    logic             r_grant_valid;
    logic             w_valid_nxt;

    logic [N-1:0]     w_mask;
    logic [N-1:0]     w_sel_onehot;
    logic [IDX_W-1:0] w_sel_index;
    logic             w_sel_valid;
    logic [IDX_W-1:0] w_sel_next_ptr;
    logic             w_cur_req;
    logic             w_hold_expire;
    logic             w_end_xfer;

`ifdef ARB_MAX_HOLD_EN
    logic [ARB_HOLD_W-1:0] r_hold_cnt;
    logic [ARB_HOLD_W-1:0] w_hold_cnt_nxt;

    // The current cycle is the MAX_HOLD-th cycle of this grant.
    assign w_hold_expire = (r_hold_cnt == ARB_HOLD_W'(MAX_HOLD - 1));
`else
    logic w_unused_max_hold;

    assign w_unused_max_hold = (MAX_HOLD == 0);
    assign w_hold_expire     = 1'b0;
`endif

    // The current grantee is excluded when re-arbitrating at the end of its transfer.
    assign w_mask     = (r_state == ARB_BUSY) ? r_grant : '0;
    assign w_cur_req  = i_request[r_grant_index];
    assign w_end_xfer = (r_state == ARB_BUSY) && (!w_cur_req || i_release || w_hold_expire);

    rr_priority_select #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_select (
        .i_req          (i_request),
        .i_mask         (w_mask),
        .i_pointer      (r_pointer),
        .o_sel_onehot_c (w_sel_onehot),
        .o_sel_index_c  (w_sel_index),
        .o_sel_valid_c  (w_sel_valid)
    );

    assign w_sel_next_ptr = (w_sel_index == IDX_W'(N - 1)) ? '0 : w_sel_index + IDX_W'(1);

    // State, pointer and grant registers.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= ARB_IDLE;
            r_pointer     <= '0;
            r_grant       <= '0;
            r_grant_index <= '0;
            r_grant_valid <= 1'b0;
`ifdef ARB_MAX_HOLD_EN
            r_hold_cnt    <= '0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_pointer     <= w_pointer_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_index <= w_index_nxt;
            r_grant_valid <= w_valid_nxt;
`ifdef ARB_MAX_HOLD_EN
            r_hold_cnt    <= w_hold_cnt_nxt;
`endif
        end
    end

    // Next-state logic: grant on request in IDLE, hold or hand over in BUSY.
    always_comb begin
        w_state_nxt    = r_state;
        w_pointer_nxt  = r_pointer;
        w_grant_nxt    = r_grant;
        w_index_nxt    = r_grant_index;
        w_valid_nxt    = r_grant_valid;
`ifdef ARB_MAX_HOLD_EN
        w_hold_cnt_nxt = r_hold_cnt;
`endif
        case (r_state)
            ARB_IDLE: begin
                if (w_sel_valid) begin
                    w_state_nxt    = ARB_BUSY;
                    w_pointer_nxt  = w_sel_next_ptr;
                    w_grant_nxt    = w_sel_onehot;
                    w_index_nxt    = w_sel_index;
                    w_valid_nxt    = 1'b1;
`ifdef ARB_MAX_HOLD_EN
                    w_hold_cnt_nxt = '0;
`endif
                end
            end
            ARB_BUSY: begin
                if (w_end_xfer) begin
                    if (w_sel_valid) begin
                        w_pointer_nxt  = w_sel_next_ptr;
                        w_grant_nxt    = w_sel_onehot;
                        w_index_nxt    = w_sel_index;
                        w_valid_nxt    = 1'b1;
`ifdef ARB_MAX_HOLD_EN
                        w_hold_cnt_nxt = '0;
`endif
                    end else begin
                        w_state_nxt    = ARB_IDLE;
                        w_grant_nxt    = '0;
                        w_index_nxt    = '0;
                        w_valid_nxt    = 1'b0;
`ifdef ARB_MAX_HOLD_EN
                        w_hold_cnt_nxt = '0;
`endif
                    end
                end else begin
`ifdef ARB_MAX_HOLD_EN
                    w_hold_cnt_nxt = r_hold_cnt + ARB_HOLD_W'(1);
`endif
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    assign o_grant       = r_grant;
    assign o_grant_index = r_grant_index;
    assign o_grant_valid = r_grant_valid;

endmodule

// File: tb/tb_round_robin_arbiter_n.sv
// Bench for round_robin_arbiter_n (N=4): reference model checked every cycle plus directed literals.
module tb_round_robin_arbiter_n;

    localparam int N        = 4;
    localparam int IDX_W    = 2;
    localparam int MAX_HOLD = 3;
`ifdef ARB_MAX_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req = '0;
    logic             rel = 1'b0;
    logic [N-1:0]     grant;
    logic [IDX_W-1:0] grant_index;
    logic             grant_valid;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: current owner (-1 = none), priority pointer, cycles owned so far.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_age   = 0;

    round_robin_arbiter_n #(
        .N        (N),
        .IDX_W    (IDX_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .i_clock       (clk),
        .i_reset_n     (rst_n),
        .i_request     (req),
        .i_release     (rel),
        .o_grant       (grant),
        .o_grant_index (grant_index),
        .o_grant_valid (grant_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int ptr, input int excl);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (ptr + k) % N;
            if (c != excl && r[c[1:0]]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_age   = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] r, input logic rl);
        int  w;
        bit  ending;
        if (m_owner < 0) begin
            w = pick(r, m_ptr, -1);
            if (w >= 0) begin
                m_owner = w;
                m_ptr   = (w + 1) % N;
                m_age   = 1;
            end
        end else begin
            ending = !r[m_owner[1:0]] || rl || (HOLD_EN && m_age >= MAX_HOLD);
            if (ending) begin
                w = pick(r, m_ptr, m_owner);
                if (w >= 0) begin
                    m_owner = w;
                    m_ptr   = (w + 1) % N;
                    m_age   = 1;
                end else begin
                    m_owner = -1;
                    m_age   = 0;
                end
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic compare_model();
        logic [N-1:0] e;
        e = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        check("model grant", 32'(grant), 32'(e));
        check("model valid", 32'(grant_valid), 32'(m_owner >= 0));
        check("onehot", 32'($countones(grant) <= 1), 32'(1));
        if (m_owner >= 0) begin
            check("model index", 32'(grant_index), 32'(m_owner));
        end
    endtask

    // Drive inputs at the falling edge, advance the model at the rising edge, compare at the next fall.
    task automatic tick(input logic [N-1:0] r, input logic rl);
        req = r;
        rel = rl;
        @(posedge clk);
        model_edge(r, rl);
        @(negedge clk);
        compare_model();
    endtask

    logic [N-1:0] rot_exp [5];
    logic [N-1:0] vec_req [10];
    logic         vec_rel [10];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] e;
        rot_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        vec_req = '{4'b0110, 4'b0110, 4'b0110, 4'b1001, 4'b1001,
                    4'b0000, 4'b0111, 4'b0101, 4'b1111, 4'b1110};
        vec_rel = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset values
        model_reset();
        repeat (2) @(negedge clk);
        check("reset grant", 32'(grant), 32'(4'b0000));
        check("reset valid", 32'(grant_valid), 32'(0));
        check("reset index", 32'(grant_index), 32'(0));
        rst_n = 1'b1;

        // First grant after reset release, then release handover with no bubble
        tick(4'b0101, 1'b0);
        check("first grant", 32'(grant), 32'(4'b0001));
        check("first index", 32'(grant_index), 32'(0));
        tick(4'b0101, 1'b0);
        check("held grant", 32'(grant), 32'(4'b0001));
        tick(4'b0101, 1'b1);
        check("release handover", 32'(grant), 32'(4'b0100));
        tick(4'b0100, 1'b0);
        check("after drop 0", 32'(grant), 32'(4'b0100));
        tick(4'b0001, 1'b0);
        check("back to 0", 32'(grant), 32'(4'b0001));
        tick(4'b0000, 1'b0);
        check("idle", 32'(grant), 32'(4'b0000));

        // Set pointer to 0 via requester 3, then rotate with release every cycle
        tick(4'b1000, 1'b0);
        check("req3 grant", 32'(grant), 32'(4'b1000));
        for (int i = 0; i < 5; i++) begin
            tick(4'b1111, 1'b1);
            check("rotation", 32'(grant), 32'(rot_exp[i]));
        end
        tick(4'b0000, 1'b0);
        check("rot idle", 32'(grant), 32'(4'b0000));

        // Single requester drop/re-raise; other requests and idle release ignored
        tick(4'b1000, 1'b0);
        check("single grant", 32'(grant), 32'(4'b1000));
        tick(4'b0000, 1'b0);
        check("single drop", 32'(grant), 32'(4'b0000));
        check("single drop valid", 32'(grant_valid), 32'(0));
        tick(4'b1000, 1'b0);
        check("single regrant", 32'(grant), 32'(4'b1000));
        check("single regrant valid", 32'(grant_valid), 32'(1));
        tick(4'b1011, 1'b0);
        check("others ignored", 32'(grant), 32'(4'b1000));
        check("others index", 32'(grant_index), 32'(3));
        tick(4'b0000, 1'b1);
        check("release end", 32'(grant), 32'(4'b0000));
        tick(4'b0000, 1'b1);
        check("idle release", 32'(grant_valid), 32'(0));

        // Asynchronous reset in the middle of a transfer
        tick(4'b0100, 1'b0);
        check("busy before reset", 32'(grant), 32'(4'b0100));
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset grant", 32'(grant), 32'(4'b0000));
        check("async reset valid", 32'(grant_valid), 32'(0));
        model_reset();
        req = 4'b0010;
        @(posedge clk);
        @(negedge clk);
        check("in reset grant", 32'(grant), 32'(4'b0000));
        rst_n = 1'b1;
        tick(4'b0010, 1'b0);
        check("post reset grant", 32'(grant), 32'(4'b0010));
        check("post reset index", 32'(grant_index), 32'(1));
        tick(4'b0000, 1'b0);
        check("post reset idle", 32'(grant), 32'(4'b0000));

        // Two steady requesters without release: hold limit alternates them
        for (int i = 0; i < 9; i++) begin
            tick(4'b0011, 1'b0);
            e = (HOLD_EN && ((i / MAX_HOLD) % 2 == 1)) ? 4'b0010 : 4'b0001;
            check("hold pattern", 32'(grant), 32'(e));
        end
        tick(4'b0000, 1'b0);

        // Mixed directed vectors, checked by the model alone
        for (int i = 0; i < 10; i++) begin
            tick(vec_req[i], vec_rel[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
